io_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the core's I/O port, downstream of the processor's store path. Consumes the core's `io_rw` write strobe, the address and the store data, and queues bytes in a small FIFO. Serialises each byte as an 8N1 frame on `tx`. Exposes a status word that the system read mux can return on I/O-window loads.

---
 rtl/io_uart_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_io_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status word

module io_uart_tx_fifo #(
  parameter int LOG2 = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [7:0]      push_data,
  input  logic            pop,
  input  logic            clr_ovf,
  output logic [7:0]      head,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic [LOG2:0]   count
);

  localparam int DEPTH = 1 << LOG2;

  logic [7:0]      mem [DEPTH];
  logic [LOG2-1:0] rptr;
  logic [LOG2-1:0] wptr;
  logic [LOG2:0]   cnt;
  logic            ovf;
  logic            push_ok;

  // Count never exceeds DEPTH, so its top bit alone marks a full buffer.
  assign full     = cnt[LOG2];
  assign empty    = (cnt == '0);
  assign head     = mem[rptr];
  assign count    = cnt;
  assign overflow = ovf;

  // A pop in the same cycle frees the slot the full-buffer push lands in.
  assign push_ok = push & (~full | pop);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + LOG2'(1);
      end
      if (pop) begin
        rptr <= rptr + LOG2'(1);
      end
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + (LOG2+1)'(1);
        2'b01:   cnt <= cnt - (LOG2+1)'(1);
        default: cnt <= cnt;
      endcase
      if (clr_ovf) begin
        ovf <= 1'b0;
      end else if (push & full & ~pop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

module io_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_LOG2    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rw,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_status,
  output logic        tx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  state_t           state, state_n;
  logic [CW-1:0]    baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_q, tx_n;
  logic             pop;
  logic             bit_end;

  logic             wr;
  logic             push;
  logic             clr_ovf;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [FIFO_LOG2:0] count;
  logic             unused_bits;

  // The I/O window is the top word of the address space; byte lane bits are ignored.
  assign wr      = io_rw & (&io_addr[31:2]);
  assign push    = wr & ~io_wdata[8];
  assign clr_ovf = wr & io_wdata[8];
  assign unused_bits = ^{io_addr[1:0], io_wdata[31:9]};

  io_uart_tx_fifo #(
    .LOG2(FIFO_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (io_wdata[7:0]),
    .pop       (pop),
    .clr_ovf   (clr_ovf),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .count     (count)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);

  // Next-state, baud timing and next tx level; tx is registered from tx_n.
  always_comb begin
    state_n    = state;
    baud_cnt_n = bit_end ? '0 : baud_cnt + CW'(1);
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    tx_n       = tx_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        tx_n       = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
          tx_n      = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n   = shift >> 1;
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n    = IDLE;
        baud_cnt_n = '0;
        tx_n       = 1'b1;
      end
    endcase
  end

  // Transmitter state register; reset aborts any frame and idles the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
    end
  end

  assign tx = tx_q;

  // Status word built only from registered state.
  always_comb begin
    io_status                  = 32'h0;
    io_status[0]               = (state != IDLE);
    io_status[1]               = full;
    io_status[2]               = empty;
    io_status[3]               = overflow;
    io_status[FIFO_LOG2+4:4]   = count;
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - self-checking bench for io_uart_tx against a frame-level model

module tb_io_uart_tx;

  localparam int CPB   = 4;
  localparam int LOG2  = 2;
  localparam int DEPTH = 1 << LOG2;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] IO_ADDR = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_rw;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_status;
  logic        tx;

  int errors = 0;
  int checks = 0;

  // Reference model: byte queue, sticky flag and the frame in flight.
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_active;
  int         m_t;
  logic [7:0] m_byte;

  always #5 clk = ~clk;

  io_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_LOG2    (LOG2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .io_rw     (io_rw),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_status (io_status),
    .tx        (tx)
  );

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int n;
    n = q.size();
    s = 32'h0;
    s[0] = m_active;
    s[1] = (n == DEPTH);
    s[2] = (n == 0);
    s[3] = m_ovf;
    s[LOG2+4:4] = n[LOG2:0];
    return s;
  endfunction

  task automatic model_edge();
    bit in_win, do_pop, done, was_full;
    logic [7:0] popped;
    popped = 8'h00;
    if (reset) begin
      q.delete();
      m_ovf = 0;
      m_active = 0;
      m_t = 0;
      return;
    end
    in_win   = io_rw && (io_addr[31:2] == 30'h3FFF_FFFF);
    done     = m_active && (m_t == FRAME - 1);
    do_pop   = (q.size() > 0) && (!m_active || done);
    was_full = (q.size() == DEPTH);
    if (do_pop) popped = q.pop_front();
    if (in_win && io_wdata[8]) m_ovf = 0;
    else if (in_win) begin
      if (!was_full || do_pop) q.push_back(io_wdata[7:0]);
      else m_ovf = 1;
    end
    if (do_pop) begin
      m_active = 1;
      m_t = 0;
      m_byte = popped;
    end else if (done) m_active = 0;
    else if (m_active) m_t++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("tx", {31'h0, tx}, {31'h0, exp_tx()});
    chk("status", io_status, exp_status());
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_rw = 1'b1;
    io_addr = a;
    io_wdata = d;
    tick();
    io_rw = 1'b0;
    io_addr = 32'h0;
    io_wdata = 32'h0;
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] b;
    int waited;
    int sel;
    reset = 1'b1;
    io_rw = 1'b0;
    io_addr = 32'h0;
    io_wdata = 32'h0;
    @(negedge clk);

    // Reset and idle
    tick();
    tick();
    chk("reset_status", io_status, 32'h0000_0004);
    chk("reset_tx", {31'h0, tx}, 32'h1);
    reset = 1'b0;
    wr(32'h0000_1000, 32'h0000_0041);
    chk("outside_window", io_status, 32'h0000_0004);
    io_addr = IO_ADDR;
    io_wdata = 32'h0000_0042;
    tick();
    io_addr = 32'h0;
    io_wdata = 32'h0;
    chk("rw_low", io_status, 32'h0000_0004);

    // Single byte 0xA5: start, LSB-first data, stop
    wr(IO_ADDR, 32'h0000_00A5);
    chk("push_count", io_status, 32'h0000_0010);
    pat = 10'b1_1010_0101_0;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < CPB; c++) begin
        tick();
        chk("a5_line", {31'h0, tx}, {31'h0, pat[k]});
      end
    end
    chk("busy_last_stop", {31'h0, io_status[0]}, 32'h1);
    tick();
    chk("busy_drop", io_status, 32'h0000_0004);

    // Back-to-back frames
    wr(IO_ADDR, 32'h0000_0055);
    wr(IO_ADDR, 32'h0000_00FF);
    idle(2 * FRAME + 5);
    chk("b2b_done", io_status, 32'h0000_0004);

    // Random bytes one at a time
    for (int i = 0; i < 3; i++) begin
      wr(IO_ADDR, {24'h0, 8'($urandom)});
      idle(FRAME + 3);
    end

    // Overflow: one pops, four queue, one drops
    for (int i = 0; i < 6; i++) wr(IO_ADDR, {24'h0, 8'($urandom)});
    chk("ovf_status", io_status, 32'h0000_004B);
    wr(IO_ADDR, 32'h0000_0100);
    chk("ovf_clear", io_status, 32'h0000_0043);

    // Push while full on the STOP->START edge
    waited = 0;
    while (!(m_active && m_t == FRAME - 1) && waited < 100) begin
      tick();
      waited++;
    end
    chk("wait_stop_end", {31'h0, (waited < 100)}, 32'h1);
    wr(IO_ADDR, 32'h0000_003C);
    chk("full_push_pop", io_status, 32'h0000_0043);
    idle(6 * FRAME);
    chk("drained", io_status, 32'h0000_0004);

    // Random bus traffic, including control writes and stray addresses
    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(0, 3));
      io_rw = ($urandom_range(0, 2) == 0);
      case (sel)
        0: io_addr = IO_ADDR;
        1: io_addr = 32'hFFFF_FFFF;
        2: io_addr = 32'h7FFF_FFFC;
        default: io_addr = $urandom;
      endcase
      io_wdata = $urandom & 32'hFFFF_FEFF;
      if ($urandom_range(0, 7) == 0) io_wdata[8] = 1'b1;
      tick();
    end
    io_rw = 1'b0;
    io_addr = 32'h0;
    io_wdata = 32'h0;
    idle(6 * FRAME);
    wr(IO_ADDR, 32'h0000_0100);
    chk("random_drained", io_status, 32'h0000_0004);

    // Reset during data bit 3 with two bytes queued
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      wr(IO_ADDR, {24'h0, b});
    end
    waited = 0;
    while (!(m_active && m_t == 4 * CPB + 1) && waited < 100) begin
      tick();
      waited++;
    end
    chk("wait_bit3", {31'h0, (waited < 100)}, 32'h1);
    chk("queued_two", io_status[LOG2+4:4], 32'h2);
    reset = 1'b1;
    tick();
    chk("midframe_tx", {31'h0, tx}, 32'h1);
    chk("midframe_status", io_status, 32'h0000_0004);
    reset = 1'b0;
    idle(3 * FRAME);
    chk("no_more_frames", io_status, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
